// File: rtl/bus_pkg.sv
// Shared types and helpers for the four-master round-robin bus arbiter.
package bus_pkg;

  localparam int unsigned NUM_MASTER = 4;
  localparam int unsigned MSEL_W     = 2;

  typedef enum logic {
    IDLE,
    GRANT
  } state_t;

  function automatic logic [NUM_MASTER-1:0] onehot2(input logic [MSEL_W-1:0] idx);
    onehot2 = 4'b0001 << idx;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Rotating priority encoder: first set bit of req scanning ptr, ptr+1, ... mod 4.
module rr_pick
  import bus_pkg::*;
(
  input  logic [NUM_MASTER-1:0] req,
  input  logic [MSEL_W-1:0]     ptr,
  output logic                  valid,
  output logic [MSEL_W-1:0]     idx
);

  logic [MSEL_W-1:0] cand;

  always_comb begin
    valid = 1'b0;
    idx   = ptr;
    cand  = ptr;
    for (int unsigned i = 0; i < NUM_MASTER; i++) begin
      cand = ptr + MSEL_W'(i);
      if (!valid && req[cand]) begin
        valid = 1'b1;
        idx   = cand;
      end
    end
  end

endmodule

// File: rtl/bus_arbiter_rr4.sv
// Four-master round-robin arbiter with bounded hold time, per-owner lock and
// a mandatory idle turnaround cycle between owners.
module bus_arbiter_rr4
  import bus_pkg::*;
#(
  parameter int unsigned MAX_HOLD = 16,
  parameter int unsigned CNT_W    = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NUM_MASTER-1:0] M_req,
  input  logic [NUM_MASTER-1:0] M_lock,
  output logic [NUM_MASTER-1:0] M_grant,
  output logic [MSEL_W-1:0]     Msel,
  output logic                  busy,
  output logic                  hold_timeout
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_HOLD - 1);

  state_t                  state_q, state_d;
  logic [MSEL_W-1:0]       ptr_q, ptr_d;
  logic [CNT_W-1:0]        hold_cnt_q, hold_cnt_d;
  logic [NUM_MASTER-1:0]   grant_q, grant_d;
  logic [MSEL_W-1:0]       msel_q, msel_d;
  logic                    timeout_q, timeout_d;

  logic                    pick_valid;
  logic [MSEL_W-1:0]       pick_idx;
  logic                    others_waiting;
  logic                    forced;

  rr_pick u_rr_pick (
    .req   (M_req),
    .ptr   (ptr_q),
    .valid (pick_valid),
    .idx   (pick_idx)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      ptr_q      <= '0;
      hold_cnt_q <= '0;
      grant_q    <= '0;
      msel_q     <= '0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      hold_cnt_q <= hold_cnt_d;
      grant_q    <= grant_d;
      msel_q     <= msel_d;
      timeout_q  <= timeout_d;
    end
  end

  // Grant, select and pulse are registered, so they are computed here as next values.
  always_comb begin
    state_d        = state_q;
    ptr_d          = ptr_q;
    hold_cnt_d     = hold_cnt_q;
    grant_d        = grant_q;
    msel_d         = msel_q;
    timeout_d      = 1'b0;
    others_waiting = |(M_req & ~onehot2(msel_q));
    forced         = M_req[msel_q] && !M_lock[msel_q] &&
                     (hold_cnt_q == CNT_MAX) && others_waiting;
    unique case (state_q)
      IDLE: begin
        if (pick_valid) begin
          grant_d    = onehot2(pick_idx);
          msel_d     = pick_idx;
          hold_cnt_d = '0;
          state_d    = GRANT;
        end
      end
      GRANT: begin
        if (!M_req[msel_q] || forced) begin
          grant_d   = '0;
          ptr_d     = msel_q + MSEL_W'(1);
          timeout_d = forced;
          state_d   = IDLE;
        end else if (hold_cnt_q != CNT_MAX) begin
          hold_cnt_d = hold_cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    M_grant      = grant_q;
    Msel         = msel_q;
    busy         = |grant_q;
    hold_timeout = timeout_q;
  end

endmodule

// File: tb/tb_bus_arbiter_rr4.sv
// Directed bench for bus_arbiter_rr4 (MAX_HOLD=4 main instance, MAX_HOLD=1 edge instance).
module tb_bus_arbiter_rr4;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] M_req, M_lock, M_grant;
  logic [1:0] Msel;
  logic       busy, hold_timeout;

  logic [3:0] req1, lock1, grant1;
  logic [1:0] msel1;
  logic       busy1, to1;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  bus_arbiter_rr4 #(.MAX_HOLD(4)) dut (
    .clk          (clk),
    .reset        (reset),
    .M_req        (M_req),
    .M_lock       (M_lock),
    .M_grant      (M_grant),
    .Msel         (Msel),
    .busy         (busy),
    .hold_timeout (hold_timeout)
  );

  bus_arbiter_rr4 #(.MAX_HOLD(1)) dut1 (
    .clk          (clk),
    .reset        (reset),
    .M_req        (req1),
    .M_lock       (lock1),
    .M_grant      (grant1),
    .Msel         (msel1),
    .busy         (busy1),
    .hold_timeout (to1)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_main(input string tag, input logic [3:0] g, input logic [1:0] s,
                             input logic to);
    check({tag, ".grant"}, 32'(M_grant), 32'(g));
    check({tag, ".msel"}, 32'(Msel), 32'(s));
    check({tag, ".busy"}, 32'(busy), 32'(|g));
    check({tag, ".timeout"}, 32'(hold_timeout), 32'(to));
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    M_req = '0; M_lock = '0; req1 = '0; lock1 = '0;
    tick();
    expect_main("reset", 4'b0000, 2'd0, 1'b0);
    check("reset.dut1_grant", 32'(grant1), 32'd0);
    reset = 1'b0;

    // Single requester, then release moves ptr to 3
    M_req = 4'b0100;
    tick();
    expect_main("m2_grant", 4'b0100, 2'd2, 1'b0);
    M_req = 4'b0000;
    tick();
    expect_main("m2_release", 4'b0000, 2'd2, 1'b0);
    M_req = 4'b1111;
    tick();
    expect_main("ptr3_win", 4'b1000, 2'd3, 1'b0);

    // All request, no lock: 4 granted cycles then a forced idle turnaround
    do_reset();
    M_req = 4'b1111;
    for (int m = 0; m < 5; m++) begin
      for (int k = 0; k < 4; k++) begin
        tick();
        expect_main($sformatf("rr_m%0d_k%0d", m, k), 4'b0001 << (m % 4), 2'(m % 4), 1'b0);
      end
      tick();
      expect_main($sformatf("rr_idle%0d", m), 4'b0000, 2'(m % 4), 1'b1);
    end

    // Lone requester keeps the bus indefinitely
    do_reset();
    M_req = 4'b0001;
    for (int k = 0; k < 40; k++) begin
      tick();
      expect_main($sformatf("solo_%0d", k), 4'b0001, 2'd0, 1'b0);
    end

    // Lock suppresses timeout; dropping lock forces release at once
    do_reset();
    M_req = 4'b0011; M_lock = 4'b0001;
    tick();
    expect_main("lock_grant", 4'b0001, 2'd0, 1'b0);
    for (int k = 0; k < 30; k++) begin
      tick();
      check($sformatf("lock_hold_%0d", k), 32'(M_grant), 32'h1);
    end
    M_lock = 4'b0000;
    tick();
    expect_main("lock_drop", 4'b0000, 2'd0, 1'b1);
    tick();
    expect_main("lock_next", 4'b0010, 2'd1, 1'b0);

    // Non-owner lock ignored; owner releasing wins over its own lock
    M_lock = 4'b1101;
    M_req  = 4'b0010;
    tick();
    expect_main("lock_rel_a", 4'b0010, 2'd1, 1'b0);
    M_lock = 4'b0010;
    M_req  = 4'b0100;
    tick();
    expect_main("lock_rel_b", 4'b0000, 2'd1, 1'b0);
    M_lock = 4'b0000;
    M_req  = 4'b0000;

    // Reset mid-grant drops grant and restores ptr 0
    do_reset();
    M_req = 4'b1000;
    tick();
    expect_main("pre_rst", 4'b1000, 2'd3, 1'b0);
    reset = 1'b1;
    M_req = 4'b1001;
    tick();
    expect_main("mid_rst", 4'b0000, 2'd0, 1'b0);
    reset = 1'b0;
    tick();
    expect_main("post_rst", 4'b0001, 2'd0, 1'b0);

    // One-cycle request yields one granted cycle; Msel held while idle
    do_reset();
    M_req = 4'b0010;
    tick();
    expect_main("pulse_grant", 4'b0010, 2'd1, 1'b0);
    M_req = 4'b0000;
    tick();
    expect_main("pulse_rel", 4'b0000, 2'd1, 1'b0);
    tick();
    expect_main("pulse_idle", 4'b0000, 2'd1, 1'b0);
    M_req = 4'b0111;
    tick();
    expect_main("ptr2_win", 4'b0100, 2'd2, 1'b0);
    M_req = 4'b0000;
    tick();

    // MAX_HOLD=1: one cycle per owner when another waits
    do_reset();
    req1 = 4'b0011;
    for (int m = 0; m < 3; m++) begin
      tick();
      check($sformatf("mh1_grant%0d", m), 32'(grant1), 32'(4'b0001 << (m % 2)));
      check($sformatf("mh1_msel%0d", m), 32'(msel1), 32'(m % 2));
      check($sformatf("mh1_to%0d", m), 32'(to1), 32'd0);
      tick();
      check($sformatf("mh1_idle%0d", m), 32'(grant1), 32'd0);
      check($sformatf("mh1_pulse%0d", m), 32'(to1), 32'd1);
    end
    req1 = 4'b0000;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
